// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver:
// frame FSM states, prefix codes and the key event layout.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_CODE_EXT = 8'hE0;
    localparam logic [7:0] PS2_CODE_BRK = 8'hF0;
    localparam int         PS2_EVT_W    = 10;

    // Field order fixes the event bit positions: brk=9, ext=8, code=7:0.
    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ps2_evt_t;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO; pointers carry an extra wrap bit so full and empty
// are distinguishable, and a push into a full queue succeeds if a pop coincides.
module ps2_evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   not_empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   dropped
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             empty, full, do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dropped = push & full & ~do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign head_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign not_empty = ~empty;
    assign level     = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: pin conditioning, 11-bit frame FSM with timeout,
// E0/F0 prefix folding into key events, and a buffered event queue.
//
//   state     | meaning
//   ST_IDLE   | waiting for a start bit (data=0 on a clock strobe)
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | capturing the odd-parity bit
//   ST_STOP   | checking stop bit and parity, then back to idle
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ps2k_clk,
    input  logic                        ps2k_data,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [PS2_EVT_W-1:0]        evt_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        frame_err,
    output logic [7:0]                  err_count,
    output logic                        overflow,
    input  logic                        err_clr
);
    localparam int FCNT_W = $clog2(FILTER_LEN);
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);

    logic              clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic              filt_q, filt_d, strobe_q, strobe_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    ps2_state_e        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d, byte_q, byte_d;
    logic              par_q, par_d, byte_vld_q, byte_vld_d, frame_err_q, frame_err_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              ext_q, ext_d, brk_q, brk_d, evt_push;
    ps2_evt_t          push_evt;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              ovf_q, ovf_d, fifo_drop;

    // Synchronisers idle high to match an undriven PS/2 bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2k_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2k_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    always_comb begin
        filt_d   = filt_q;
        fcnt_d   = '0;
        strobe_d = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
                filt_d   = clk_s2_q;
                strobe_d = ~clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        byte_d      = byte_q;
        byte_vld_d  = 1'b0;
        frame_err_d = 1'b0;
        // Loaded with TIMEOUT_CYCLES-2 so the abort pulse lands TIMEOUT_CYCLES after the strobe.
        if (state_q == ST_IDLE || strobe_q) tmr_d = TMR_W'(TIMEOUT_CYCLES - 2);
        else if (tmr_q != '0)               tmr_d = tmr_q - 1'b1;
        else                                tmr_d = tmr_q;

        case (state_q)
            ST_IDLE: begin
                if (strobe_q && !dat_s2_q) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (strobe_q) begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (strobe_q) begin
                    par_d   = dat_s2_q;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (strobe_q) begin
                    state_d = ST_IDLE;
                    if (dat_s2_q && odd_parity_ok(shift_q, par_q)) begin
                        byte_vld_d = 1'b1;
                        byte_d     = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE && !strobe_q && tmr_q == '0) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
        end
    end

    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        evt_push = 1'b0;
        if (frame_err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_vld_q) begin
            if (byte_q == PS2_CODE_EXT)      ext_d = 1'b1;
            else if (byte_q == PS2_CODE_BRK) brk_d = 1'b1;
            else begin
                evt_push = 1'b1;
                ext_d    = 1'b0;
                brk_d    = 1'b0;
            end
        end
    end

    assign push_evt = '{brk: brk_q, ext: ext_q, code: byte_q};

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr)                                 err_cnt_d = '0;
        else if (frame_err_q && err_cnt_q != 8'hFF)  err_cnt_d = err_cnt_q + 1'b1;
        ovf_d = ovf_q;
        if (fifo_drop)    ovf_d = 1'b1;
        else if (err_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q      <= 1'b1;
            fcnt_q      <= '0;
            strobe_q    <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            byte_q      <= '0;
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            tmr_q       <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            err_cnt_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            strobe_q    <= strobe_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            byte_q      <= byte_d;
            byte_vld_q  <= byte_vld_d;
            frame_err_q <= frame_err_d;
            tmr_q       <= tmr_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            err_cnt_q   <= err_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    ps2_evt_fifo #(
        .WIDTH (PS2_EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (evt_push),
        .push_data (push_evt),
        .pop       (evt_valid & evt_ready),
        .head_data (evt_data),
        .not_empty (evt_valid),
        .level     (fifo_level),
        .dropped   (fifo_drop)
    );

    assign frame_err = frame_err_q;
    assign err_count = err_cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/ps2_key_rx.md
# ps2_key_rx

Parametrised PS/2 keyboard receiver with on-chip event queue, successor to the scoreboard's first-generation scanner. Runs entirely in the system clock domain: oversamples and deglitches `ps2k_clk`/`ps2k_data`, deframes 11-bit frames with parity/stop/timeout checking, folds `E0`/`F0` prefixes into make/break/extended key events, and buffers events in a FIFO drained through a valid/ready handshake by the scoreboard controller.

## Interface
- `FILTER_LEN`, 4: consecutive identical synchronised samples required before filtered PS/2 clock changes (≥2).
- `TIMEOUT_CYCLES`, 50000: clocks without a filtered falling edge before an in-progress frame is aborted (≈1 ms at 50 MHz).
- `FIFO_DEPTH`, 8: event queue entries; power of two, ≥2.
- `clk` in 1: system clock; sole clock of the block.
- `reset` in 1: asynchronous, active-high; clears all state.
- `ps2k_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2k_data` in 1: raw PS/2 data pin, asynchronous.
- `evt_valid` out 1: FIFO non-empty; head event on `evt_data`.
- `evt_ready` in 1: consumer accepts head event when `evt_valid & evt_ready`.
- `evt_data` out 10: `{brk, ext, code[7:0]}` of head event.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: occupied entries.
- `frame_err` out 1: one-cycle pulse per dropped frame (parity, stop or timeout).
- `err_count` out 8: saturating count of `frame_err` pulses.
- `overflow` out 1: sticky; set when an event is dropped because FIFO full.
- `err_clr` in 1: synchronous; clears `err_count` and `overflow`.

## Operation
- Input conditioning: both pins through 2-flop synchronisers; `ps2k_data` sampled from synchroniser output. Filtered clock (reset value 1) takes synchronised clock value after FILTER_LEN equal consecutive samples. Sample strobe = filtered clock 1→0.
- Frame FSM states: IDLE, DATA, PARITY, STOP. On strobe: IDLE with data=0 → DATA (bit count 0); data=1 stays IDLE. DATA shifts bit in LSB-first; after 8th bit → PARITY. PARITY stores bit → STOP. STOP: frame good iff stop=1 and data+parity has odd ones; always → IDLE.
- Bad parity or stop=0: frame dropped, `frame_err` pulse. In DATA/PARITY/STOP with TIMEOUT_CYCLES clocks since last strobe: → IDLE, `frame_err` pulse, partial byte discarded. Timer reset on every strobe and in IDLE.
- Decoder on good byte: `E0` sets ext flag; `F0` sets brk flag; any other byte pushes `{brk, ext, byte}` and clears both flags. Any `frame_err` also clears both flags. `E0 F0 75` → one event `{1,1,75}`.
- FIFO: push accepted when `fifo_level < FIFO_DEPTH` or a pop occurs same cycle; otherwise event dropped, `overflow` set. Pop when `evt_valid & evt_ready`; ready while empty is ignored. Order preserved.
- `err_count` saturates at 255; `err_clr` coincident with `frame_err` → count 0 (clear wins). `err_clr` with overflow drop same cycle → `overflow` stays 1 (set wins).
- Reset values: `evt_valid`=0, `evt_data`=0, `fifo_level`=0, `frame_err`=0, `err_count`=0, `overflow`=0; FSM IDLE, flags clear, filtered clock 1. Reset mid-frame discards the frame; no event emitted.

## Timing
- Pin edge to strobe: 2 (sync) + FILTER_LEN cycles.
- Stop-bit strobe at cycle N: good byte registered N+1; push at N+1; `evt_valid`=1 and `fifo_level` updated at N+2 (FIFO previously empty). `frame_err` asserted at N+1 for stop/parity errors; at cycle timer reaches TIMEOUT_CYCLES for timeouts.
- Pop: `evt_data` shows next entry and `fifo_level` decrements the cycle after handshake; `evt_data` holds stable while `evt_valid & ~evt_ready`.
- Consumer may hold `evt_ready` high continuously; one event per cycle max throughput.

## Structure
- Package `ps2_pkg`: FSM state enum; `PS2_CODE_EXT`=8'hE0, `PS2_CODE_BRK`=8'hF0; `PS2_EVT_W`=10 and event struct/field positions.
- Sub-module `ps2_evt_fifo`: synchronous FIFO, parametrised width/depth, pointer wrap via extra MSB, simultaneous push/pop when full supported. Synchroniser, filter, FSM and decoder remain in `ps2_key_rx`.

## Test plan
- Frame `1C` (parity 0, stop 1), `evt_ready`=1 → one handshake with `evt_data`=10'h01C; `frame_err` never pulses.
- Sequence `E0 F0 75` → single event 10'h375; `F0 1C` → 10'h21C.
- Frame `1C` with parity 1 → `frame_err` pulse, `err_count`=1, no event; following good `1B` → 10'h01B with no stale flags.
- Clock stops after 4 data bits, TIMEOUT_CYCLES=100 → `frame_err` exactly 100 cycles after last strobe, FSM IDLE; next full frame decodes correctly.
- `evt_ready`=0, FIFO_DEPTH=4, send 5 make codes → `fifo_level`=4, `overflow`=1, first four codes drained in order; `err_clr` → `overflow`=0.
- 1-cycle glitches on `ps2k_clk` (FILTER_LEN=4) during frame `29` → event 10'h029, no errors; `reset` asserted mid-frame → all outputs at reset values, no event.
